// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, status flag bit
// positions, FSM state encoding and iterative-unit mode select.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDC = 4'h2;
  localparam logic [3:0] OP_SUBC = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_LSL  = 4'h8;
  localparam logic [3:0] OP_LSR  = 4'h9;
  localparam logic [3:0] OP_DIV  = 4'hA;
  localparam logic [3:0] OP_ASR  = 4'hB;
  localparam logic [3:0] OP_ROL  = 4'hC;
  localparam logic [3:0] OP_ROR  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_CMP  = 4'hF;

  // Status register bit positions: {V,S,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;

  // Iterative unit mode select
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mc_mul_div_iter.sv
// Shared WIDTH-cycle shift-add multiplier / restoring divider.
// start loads the operands; each following cycle performs one step.
// hi/lo present the value *after* the current step, and done is high
// during the last step, so a consumer registering hi/lo while done is
// high captures the final product or quotient/remainder.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

  // One multiply step (add-then-shift right) and one restoring divide step
  // (shift left, trial subtract, keep or restore), selected by mode.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};
    if (!div_trial[WIDTH]) begin
      div_hi = div_trial[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      div_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
    hi   = (mode_q == MODE_DIV) ? div_hi : mul_hi;
    lo   = (mode_q == MODE_DIV) ? div_lo : mul_lo;
    done = busy && (cnt == CW'(WIDTH - 1));
  end

  // Operand load on start, then WIDTH step updates while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      mode_q <= MODE_MUL;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_q <= mode;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= a;
      opb_q  <= b;
    end else if (busy) begin
      hi_q <= hi;
      lo_q <= lo;
      cnt  <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Parametrised multi-cycle ALU with valid/ready operand and result ports.
// Single-cycle ops are evaluated combinationally from the live inputs and
// captured on the accept edge; MUL and DIV (b!=0) run in mul_div_iter.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready; in_ready is high only in IDLE. A result is
// presented while out_valid is high and is consumed on a rising edge where
// out_valid && out_ready; until then all outputs hold. Inputs offered while
// in_ready is low are neither sampled nor remembered.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_high,
  output logic [3:0]       sreg,
  output logic [1:0]       dbg_state
);

  localparam int M = WIDTH - 1;

  alu_state_e state, state_nxt;

  logic             accept;
  logic             go_iter;
  logic [3:0]       op_q;
  logic [SHW-1:0]   n;
  logic             cin;

  logic [WIDTH:0]     add_ext, sub_ext;
  logic [WIDTH:0]     lsl_ext, lsr_ext, asr_ext;
  logic [2*WIDTH-1:0] rol_dbl, ror_dbl;

  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_c, sc_v;
  logic [3:0]       sc_flags;

  logic [WIDTH-1:0] it_hi, it_lo;
  logic             it_done;
  logic [3:0]       it_flags;

  assign accept    = in_valid && in_ready;
  assign go_iter   = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign dbg_state = state;
  assign n         = b[SHW-1:0];
  assign cin       = ((op == OP_ADDC) || (op == OP_SUBC)) ? sreg[FLAG_C] : 1'b0;

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (accept && go_iter),
    .mode  ((op == OP_DIV) ? MODE_DIV : MODE_MUL),
    .a     (a),
    .b     (b),
    .hi    (it_hi),
    .lo    (it_lo),
    .done  (it_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: single-cycle ops and DIV by zero go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = go_iter ? ST_ITER : ST_DONE;
      ST_ITER: if (it_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle datapath. Extended vectors carry the shifted-out bit so
  // that a zero shift amount naturally yields C=0.
  always_comb begin
    add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    lsl_ext = {1'b0, a} << n;
    lsr_ext = {a, 1'b0} >> n;
    asr_ext = $signed({a, 1'b0}) >>> n;
    rol_dbl = {a, a} << n;
    ror_dbl = {a, a} >> n;
    sc_res  = '0;
    sc_hi   = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        sc_res = add_ext[M:0];
        sc_c   = add_ext[WIDTH];
        sc_v   = (a[M] == b[M]) && (sc_res[M] != a[M]);
      end
      OP_SUB, OP_SUBC: begin
        sc_res = sub_ext[M:0];
        sc_c   = sub_ext[WIDTH];
        sc_v   = (a[M] != b[M]) && (sc_res[M] != a[M]);
      end
      OP_XOR:  sc_res = a ^ b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NAND: sc_res = ~(a & b);
      OP_LSL: begin
        sc_res = lsl_ext[M:0];
        sc_c   = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        sc_res = lsr_ext[WIDTH:1];
        sc_c   = lsr_ext[0];
      end
      OP_ASR: begin
        sc_res = asr_ext[WIDTH:1];
        sc_c   = asr_ext[0];
      end
      OP_ROL: begin
        sc_res = rol_dbl[2*WIDTH-1:WIDTH];
        sc_c   = (n != '0) && sc_res[0];
      end
      OP_ROR: begin
        sc_res = ror_dbl[M:0];
        sc_c   = (n != '0) && sc_res[M];
      end
      OP_DIV: begin
        // Only reached for b==0; nonzero divisors take the iterative path.
        sc_res = '1;
        sc_hi  = a;
        sc_v   = 1'b1;
      end
      default: ;
    endcase
    sc_flags = 4'b0000;
    if (op == OP_CMP) begin
      sc_res           = '0;
      sc_flags[FLAG_Z] = (a == b);
      sc_flags[FLAG_C] = (a < b);
      sc_flags[FLAG_S] = ($signed(a) < $signed(b));
    end else begin
      sc_flags[FLAG_Z] = (sc_res == '0);
      sc_flags[FLAG_C] = sc_c;
      sc_flags[FLAG_S] = sc_res[M];
      sc_flags[FLAG_V] = sc_v;
    end
  end

  // Flags for iterative results: MUL takes S from the high half.
  always_comb begin
    it_flags         = 4'b0000;
    it_flags[FLAG_Z] = (it_lo == '0);
    it_flags[FLAG_S] = (op_q == OP_MUL) ? it_hi[M] : it_lo[M];
  end

  // Result/status registers, loaded only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OP_ADD;
      result      <= '0;
      result_high <= '0;
      sreg        <= '0;
    end else if (accept) begin
      op_q <= op;
      if (!go_iter) begin
        result      <= sc_res;
        result_high <= sc_hi;
        sreg        <= sc_flags;
      end
    end else if ((state == ST_ITER) && it_done) begin
      result      <= it_lo;
      result_high <= it_hi;
      sreg        <= it_flags;
    end
  end

endmodule
